noc_packetizer: RTL and testbench

- Transmit-side node interface that injects traffic into one NoC router input port.
- Accepts one wide packet per valid/ready handshake from a module and splits it into FLIT_WIDTH flits carrying head, tail and destination fields.
- Drives the flits into the router under credit-based flow control.
- One instance per node; the flit output feeds that node's router input bus.

---
 rtl/noc_packetizer.sv | 150 +++++++++++++++
 tb/tb_noc_packetizer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - wide packet to credit-flow-controlled NoC flit serializer
//
// Accepts one DATA_WIDTH packet per in_valid/in_ready handshake and drives it
// into a router input port as NUM_FLITS flits of FLIT_WIDTH bits, one per
// cycle while the router has free buffer slots (credits).
//
// Flit layout: {valid, head, tail, dest[DEST_WIDTH-1:0], payload[PAYLOAD_W-1:0]}
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    packet offered
//   in_ready    packet can be accepted (high whenever idle)
//   in_data     packet payload, DATA_WIDTH bits
//   in_dest     destination node id, DEST_WIDTH bits
//   flit_out    registered flit to router; all zero when no flit is sent
//   credit_in   one-cycle pulse: router freed one buffer slot
//   busy        a packet is being serialized
//   credit_err  sticky: credit returned while already holding BUFFER_DEPTH
//   pkt_count   (NOC_PACKETIZER_STATS_EN) tail flits emitted, wrapping
//   stall_count (NOC_PACKETIZER_STATS_EN) SEND cycles without credit, saturating
//
// Optional feature macro: NOC_PACKETIZER_STATS_EN
module noc_packetizer #(
  parameter int FLIT_WIDTH   = 150,
  parameter int DATA_WIDTH   = 512,
  parameter int DEST_WIDTH   = 4,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  output logic [FLIT_WIDTH-1:0] flit_out,
  input  logic                  credit_in,
  output logic                  busy,
  output logic                  credit_err
`ifdef NOC_PACKETIZER_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int PAYLOAD_W = FLIT_WIDTH - 3 - DEST_WIDTH;
  localparam int NUM_FLITS = (DATA_WIDTH + PAYLOAD_W - 1) / PAYLOAD_W;
  localparam int CW        = $clog2(BUFFER_DEPTH + 1);
  localparam int IW        = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int PAD_W     = NUM_FLITS * PAYLOAD_W;

  localparam logic [CW-1:0] FULL     = CW'(BUFFER_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FLITS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         credits;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [PAYLOAD_W-1:0]  slice_q [NUM_FLITS];
  logic [PAD_W-1:0]      padded;
  logic                  accept;
  logic                  send;
  logic                  last;
  logic [FLIT_WIDTH-1:0] flit_next;

  // Zero-extend the packet so the final flit carries zeros above DATA_WIDTH.
  always_comb begin
    padded                 = '0;
    padded[DATA_WIDTH-1:0] = in_data;
  end

  assign last      = (idx == LAST_IDX);
  assign flit_next = {1'b1, (idx == '0), last, dest_q, slice_q[idx]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    send       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = SEND;
      end
      SEND: begin
        busy = 1'b1;
        // Only the registered count gates a send; a credit arriving now is
        // usable from the next cycle.
        send = (credits != '0);
        if (send && last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet storage needs no reset: it is only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      dest_q <= in_dest;
      for (int k = 0; k < NUM_FLITS; k++)
        slice_q[k] <= padded[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      credits    <= FULL;
      credit_err <= 1'b0;
      flit_out   <= '0;
    end else begin
      flit_out <= send ? flit_next : '0;

      if (accept)    idx <= '0;
      else if (send) idx <= last ? '0 : idx + IW'(1);

      // A send and a returned credit in the same cycle cancel out.
      if (send && !credit_in) begin
        credits <= credits - CW'(1);
      end else if (!send && credit_in) begin
        if (credits == FULL) credit_err <= 1'b1;
        else                 credits    <= credits + CW'(1);
      end
    end
  end

`ifdef NOC_PACKETIZER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (send && last) pkt_count <= pkt_count + 32'd1;
      if (state == SEND && credits == '0 && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - self-checking bench for noc_packetizer
module tb_noc_packetizer;

  logic         clk;
  logic         rst_a, rst_b;
  logic         iv_a, iv_b, ci_a, ci_b;
  logic         rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;
  logic [511:0] data_a, data_b;
  logic [3:0]   dest_a, dest_b;
  logic [149:0] flit_a, flit_b;
`ifdef NOC_PACKETIZER_STATS_EN
  logic [31:0]  pkt_a, pkt_b, stall_a, stall_b;
`endif

  int checks = 0;
  int errors = 0;

  noc_packetizer dut_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(rdy_a),
    .in_data(data_a), .in_dest(dest_a), .flit_out(flit_a),
    .credit_in(ci_a), .busy(busy_a), .credit_err(err_a)
`ifdef NOC_PACKETIZER_STATS_EN
    , .pkt_count(pkt_a), .stall_count(stall_a)
`endif
  );

  noc_packetizer #(.BUFFER_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(rdy_b),
    .in_data(data_b), .in_dest(dest_b), .flit_out(flit_b),
    .credit_in(ci_b), .busy(busy_b), .credit_err(err_b)
`ifdef NOC_PACKETIZER_STATS_EN
    , .pkt_count(pkt_b), .stall_count(stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    logic ci;
    int   fidx;   // expected flit number on flit_out, -1 for all-zero bus
    logic rdy;
    logic bsy;
    int   cr;     // expected credit count
    logic err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic iv, logic ci, int fidx, logic rdy,
                              logic bsy, int cr, logic err);
    vec_t v;
    v.iv = iv; v.ci = ci; v.fidx = fidx; v.rdy = rdy;
    v.bsy = bsy; v.cr = cr; v.err = err;
    return v;
  endfunction

  // Reference flit built straight from the documented layout.
  function automatic logic [149:0] exp_flit(int k, logic [3:0] d, logic [511:0] data);
    logic [571:0] pad;
    logic [149:0] f;
    pad = '0;
    pad[511:0] = data;
    f = '0;
    f[149] = 1'b1;
    f[148] = (k == 0);
    f[147] = (k == 3);
    f[146:143] = d;
    f[142:0] = pad[k*143 +: 143];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [149:0] act, input logic [149:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc_b(input logic iv, input logic ci, input int fidx,
                       input logic rdy, input logic bsy, input string tag);
    iv_b = iv;
    ci_b = ci;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " flit"}, flit_b, (fidx < 0) ? 150'b0 : exp_flit(fidx, 4'd9, data_b));
    chk({tag, " in_ready"}, rdy_b, rdy);
    chk({tag, " busy"}, busy_b, bsy);
  endtask

  logic [511:0] data2;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; ci_a = 1'b0; ci_b = 1'b0;
    for (int i = 0; i < 64; i++) begin
      data_a[8*i +: 8] = 8'(i);
      data_b[8*i +: 8] = 8'(255 - i);
    end
    dest_a = 4'd5;
    dest_b = 4'd9;
    data2  = ~data_a;

    // Single packet, back-to-back credit return, starvation, excess credit.
    vq.push_back(mk(1,0,-1,0,1,8,0));
    vq.push_back(mk(0,0, 0,0,1,7,0));
    vq.push_back(mk(0,0, 1,0,1,6,0));
    vq.push_back(mk(0,0, 2,0,1,5,0));
    vq.push_back(mk(0,0, 3,1,0,4,0));
    vq.push_back(mk(0,0,-1,1,0,4,0));
    vq.push_back(mk(1,0,-1,0,1,4,0));
    vq.push_back(mk(0,0, 0,0,1,3,0));
    vq.push_back(mk(0,0, 1,0,1,2,0));
    vq.push_back(mk(0,0, 2,0,1,1,0));
    vq.push_back(mk(0,0, 3,1,0,0,0));
    vq.push_back(mk(0,1,-1,1,0,1,0));
    vq.push_back(mk(1,0,-1,0,1,1,0));
    vq.push_back(mk(0,1, 0,0,1,1,0));
    vq.push_back(mk(0,1, 1,0,1,1,0));
    vq.push_back(mk(0,1, 2,0,1,1,0));
    vq.push_back(mk(0,1, 3,1,0,1,0));
    vq.push_back(mk(0,0,-1,1,0,1,0));
    vq.push_back(mk(1,0,-1,0,1,1,0));
    vq.push_back(mk(0,0, 0,0,1,0,0));
    vq.push_back(mk(0,0,-1,0,1,0,0));
    vq.push_back(mk(0,0,-1,0,1,0,0));
    vq.push_back(mk(0,1,-1,0,1,1,0));
    vq.push_back(mk(0,0, 1,0,1,0,0));
    vq.push_back(mk(0,1,-1,0,1,1,0));
    vq.push_back(mk(0,0, 2,0,1,0,0));
    vq.push_back(mk(0,1,-1,0,1,1,0));
    vq.push_back(mk(0,0, 3,1,0,0,0));
    for (int c = 1; c <= 8; c++) vq.push_back(mk(0,1,-1,1,0,c,0));
    vq.push_back(mk(0,1,-1,1,0,8,1));
    vq.push_back(mk(0,0,-1,1,0,8,1));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset flit_out", flit_a, '0);
    chk("reset busy", busy_a, 1'b0);
    chk("reset credit_err", err_a, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", rdy_a, 1'b1);
    chk("post-reset credits", dut_a.credits, 8);
    chk("post-reset flit_out b", flit_b, '0);

    for (int i = 0; i < vq.size(); i++) begin
      iv_a = vq[i].iv;
      ci_a = vq[i].ci;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d flit", i), flit_a,
          (vq[i].fidx < 0) ? 150'b0 : exp_flit(vq[i].fidx, 4'd5, data_a));
      chk($sformatf("v%0d in_ready", i), rdy_a, vq[i].rdy);
      chk($sformatf("v%0d busy", i), busy_a, vq[i].bsy);
      chk($sformatf("v%0d credits", i), dut_a.credits, vq[i].cr);
      chk($sformatf("v%0d credit_err", i), err_a, vq[i].err);
      if (vq[i].fidx == 3)
        chk($sformatf("v%0d tail pad zero", i), flit_a[142:83], '0);
    end
    iv_a = 1'b0;
    ci_a = 1'b0;

    // Credit starvation with a two-slot router buffer.
    cyc_b(1, 0, -1, 0, 1, "b0");
    cyc_b(0, 0,  0, 0, 1, "b1");
    cyc_b(0, 0,  1, 0, 1, "b2");
    cyc_b(0, 0, -1, 0, 1, "b3");
    cyc_b(0, 0, -1, 0, 1, "b4");
    cyc_b(0, 1, -1, 0, 1, "b5");
    cyc_b(0, 0,  2, 0, 1, "b6");
    cyc_b(0, 1, -1, 0, 1, "b7");
    cyc_b(0, 0,  3, 1, 0, "b8");
    chk("b credit_err", err_b, 1'b0);
`ifdef NOC_PACKETIZER_STATS_EN
    chk("b stall_count", stall_b, 32'd4);
    chk("b pkt_count", pkt_b, 32'd1);
`endif

    // Reset in the middle of a packet.
    iv_a = 1'b1;
    @(posedge clk); @(negedge clk);
    iv_a = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("pre-reset flit1", flit_a, exp_flit(1, 4'd5, data_a));
    #2 rst_a = 1'b0;
    #1;
    chk("mid-reset flit_out", flit_a, '0);
    chk("mid-reset busy", busy_a, 1'b0);
    chk("mid-reset credit_err", err_a, 1'b0);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("after reset in_ready", rdy_a, 1'b1);
    chk("after reset credits", dut_a.credits, 8);
    chk("after reset flit_out", flit_a, '0);
    data_a = data2;
    dest_a = 4'd3;
    iv_a = 1'b1;
    @(posedge clk); @(negedge clk);
    iv_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("restart head flit", flit_a, exp_flit(0, 4'd3, data2));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("restart idle in_ready", rdy_a, 1'b1);

    // Back-to-back packets with in_valid held high; credit returned on every
    // sending cycle so the count stays at 8.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 15; j++) begin
      iv_a = 1'b1;
      ci_a = (j % 5 != 0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("btb%0d valid", j), flit_a[149], (j % 5 != 0));
      chk($sformatf("btb%0d head", j), flit_a[148], (j % 5 == 1));
      chk($sformatf("btb%0d tail", j), flit_a[147], (j % 5 == 4));
    end
    iv_a = 1'b0;
    ci_a = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("btb end flit_out", flit_a, '0);
    chk("btb end credits", dut_a.credits, 8);
`ifdef NOC_PACKETIZER_STATS_EN
    chk("btb pkt_count", pkt_a, 32'd3);
    chk("btb stall_count", stall_a, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
